// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared
// memory port, qualifying decoder level signals into per-state strobes.
module multicycle_seq #(
    parameter int MUL_LAT = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [8:0]  opcode,
    input  logic [2:0]  RorI,
    input  logic        regWrite_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [1:0]  PCSrc_in,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSel,
    output logic        regWrite,
    output logic        illegal,
    output logic        fault,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_e;

    // Last wait count before giving up, and EXEC reload for 3-operand ops.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  exec_q, exec_d;
    logic        legal_q, legal_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;

    logic op_ri;
    logic op_mul;
    logic op_jmp;
    logic rori_ok;
    logic dec_legal;

    // Classify the opcode held in IR into legal instruction groups.
    always_comb begin
        op_ri  = 1'b0;
        op_mul = 1'b0;
        op_jmp = 1'b0;
        case (opcode)
            9'h1B6, 9'h1B8, 9'h106, 9'h057, 9'h056,
            9'h08C, 9'h08D, 9'h08E, 9'h08F: op_ri = 1'b1;
            9'h144, 9'h145, 9'h147:         op_mul = 1'b1;
            9'h1FF, 9'h1FE, 9'h1DD, 9'h1ED: op_jmp = 1'b1;
            default: ;
        endcase
        rori_ok   = (RorI == 3'b111) || (RorI == 3'b000);
        dec_legal = (op_ri & rori_ok) | op_mul | op_jmp;
    end

    // Next-state, wait/exec counters, legal flag and retire count.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        exec_d    = exec_q;
        legal_d   = legal_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        unique case (state_q)
            S_IDLE: begin
                if (!halt) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                legal_d = dec_legal;
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_WB;
                end else begin
                    state_d = S_EXEC;
                    exec_d  = op_mul ? MUL_CNT : 4'd0;
                end
            end
            S_EXEC: begin
                if (exec_q != 4'd0) begin
                    exec_d = exec_q - 4'd1;
                end else if (memRead_in | memWrite_in) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                retired_d = retired_q + 16'd1;
                if (halt) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers; async reset parks in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            exec_q    <= 4'd0;
            legal_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            exec_q    <= exec_d;
            legal_q   <= legal_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Moore strobe decode of the state; irWrite also needs the fetch ack.
    always_comb begin
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSel        = 2'b00;
        regWrite     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                mem_rd  = 1'b1;
                irWrite = mem_ack;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_rd       = memRead_in;
                mem_wr       = memWrite_in;
            end
            S_WB: begin
                pcWrite  = 1'b1;
                pcSel    = legal_q ? PCSrc_in : 2'b00;
                regWrite = regWrite_in & legal_q;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign fault   = (state_q == S_FAULT);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed per-cycle strobe vectors for the
// multicycle sequencer, MUL_LAT=3 and TIMEOUT=4.
module tb_multicycle_seq;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [8:0]  opcode;
    logic [2:0]  RorI;
    logic        regWrite_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic [1:0]  PCSrc_in;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_addr_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSel;
    logic        regWrite;
    logic        illegal;
    logic        fault;
    logic [15:0] retired;

    int nvec;
    int nerr;

    // {req, addr_sel, rd, wr, irWrite, pcWrite, pcSel, regWrite, fault}
    logic [9:0] obs;
    assign obs = {mem_req, mem_addr_sel, mem_rd, mem_wr, irWrite,
                  pcWrite, pcSel, regWrite, fault};

    localparam logic [9:0] V_FA  = 10'b1010100000;
    localparam logic [9:0] V_FN  = 10'b1010000000;
    localparam logic [9:0] V_Z   = 10'b0000000000;
    localparam logic [9:0] V_WR  = 10'b0000010010;
    localparam logic [9:0] V_WN  = 10'b0000010000;
    localparam logic [9:0] V_WJ  = 10'b0000010110;
    localparam logic [9:0] V_MR  = 10'b1110000000;
    localparam logic [9:0] V_MW  = 10'b1101000000;
    localparam logic [9:0] V_FLT = 10'b0000000001;

    multicycle_seq #(.MUL_LAT(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .opcode(opcode), .RorI(RorI),
        .regWrite_in(regWrite_in), .memRead_in(memRead_in),
        .memWrite_in(memWrite_in), .PCSrc_in(PCSrc_in),
        .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_addr_sel(mem_addr_sel), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .irWrite(irWrite), .pcWrite(pcWrite),
        .pcSel(pcSel), .regWrite(regWrite), .illegal(illegal),
        .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_dec(input logic [8:0] op, input logic [2:0] ri,
                           input logic rw, input logic mr,
                           input logic mw, input logic [1:0] pcs);
        opcode      = op;
        RorI        = ri;
        regWrite_in = rw;
        memRead_in  = mr;
        memWrite_in = mw;
        PCSrc_in    = pcs;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b1; mem_ack = 1'b0;
        set_dec(9'h000, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (obs !== V_Z) begin
            nerr++; $display("FAIL reset_strobes: got %b want %b", obs, V_Z);
        end
        nvec++;
        if (retired !== 16'd0 || illegal !== 1'b0) begin
            nerr++;
            $display("FAIL reset_regs: got ret=%0d ill=%b want 0 0",
                     retired, illegal);
        end
        rst = 1'b0; halt = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [9:0] ev [4] = '{V_FA, V_Z, V_Z, V_WR};
        logic       ak [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        set_dec(9'h1B6, 3'b111, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL alu c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (retired !== 16'd1) begin
            nerr++; $display("FAIL alu_retired: got %0d want 1", retired);
        end
    endtask

    task automatic test_load();
        logic [9:0] ev [7] = '{V_FA, V_Z, V_Z, V_MR, V_MR, V_MR, V_WR};
        logic       ak [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        set_dec(9'h057, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 7; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL load c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [9:0] ev [5] = '{V_FA, V_Z, V_Z, V_MW, V_WN};
        logic       ak [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        set_dec(9'h056, 3'b111, 1'b0, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL store c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muladd();
        logic [9:0] ev [6] = '{V_FA, V_Z, V_Z, V_Z, V_Z, V_WR};
        logic       ak [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        set_dec(9'h144, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL muladd c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        logic [9:0] ev [4] = '{V_FA, V_Z, V_Z, V_WJ};
        logic       ak [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        set_dec(9'h1FE, 3'b010, 1'b1, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL jump c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [9:0] ev [3] = '{V_FA, V_Z, V_WN};
        logic       ak [3] = '{1'b1, 1'b0, 1'b0};
        nvec++;
        if (illegal !== 1'b0) begin
            nerr++; $display("FAIL illegal_pre: got %b want 0", illegal);
        end
        set_dec(9'h000, 3'b111, 1'b1, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL illegal c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (illegal !== 1'b1 || retired !== 16'd6) begin
            nerr++;
            $display("FAIL illegal_post: got ill=%b ret=%0d want 1 6",
                     illegal, retired);
        end
    endtask

    task automatic test_halt();
        logic [9:0] ev [7] = '{V_FA, V_Z, V_Z, V_WR, V_Z, V_Z, V_Z};
        logic       hl [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_dec(9'h1B6, 3'b111, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 7; i++) begin
            mem_ack = 1'b1; halt = hl[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL halt c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        mem_ack = 1'b1; #1;
        nvec++;
        if (obs !== V_FA) begin
            nerr++; $display("FAIL halt_resume: got %b want %b", obs, V_FA);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        logic [9:0] ev [3] = '{V_FA, V_Z, V_Z};
        nvec++;
        if (retired !== 16'd8) begin
            nerr++; $display("FAIL midrst_retired: got %0d want 8", retired);
        end
        set_dec(9'h057, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 0); #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL midrst c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; #1;
        nvec++;
        if (obs !== 10'b1111000000) begin
            nerr++;
            $display("FAIL midrst_mem: got %b want 1111000000", obs);
        end
        rst = 1'b1; #1;
        nvec++;
        if (obs !== V_Z || retired !== 16'd0 || illegal !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_drop: got %b ret=%0d ill=%b want %b 0 0",
                     obs, retired, illegal, V_Z);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bad_rori();
        logic [9:0] ev [3] = '{V_FA, V_Z, V_WN};
        set_dec(9'h1B8, 3'b001, 1'b1, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 0); #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL badrori c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (illegal !== 1'b1 || retired !== 16'd1) begin
            nerr++;
            $display("FAIL badrori_post: got ill=%b ret=%0d want 1 1",
                     illegal, retired);
        end
    endtask

    task automatic test_timeout_edge();
        logic [9:0] ev [7] = '{V_FN, V_FN, V_FN, V_FA, V_Z, V_Z, V_WR};
        logic       ak [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        set_dec(9'h1B6, 3'b111, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 7; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL toedge c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (retired !== 16'd2) begin
            nerr++; $display("FAIL toedge_retired: got %0d want 2", retired);
        end
    endtask

    task automatic test_fault();
        logic [9:0] ev [7] = '{V_FN, V_FN, V_FN, V_FN, V_FLT, V_FLT, V_FLT};
        logic       ak [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            mem_ack = ak[i]; #1;
            nvec++;
            if (obs !== ev[i]) begin
                nerr++; $display("FAIL fault c%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (retired !== 16'd2) begin
            nerr++; $display("FAIL fault_retired: got %0d want 2", retired);
        end
        rst = 1'b1; #1;
        nvec++;
        if (obs !== V_Z) begin
            nerr++; $display("FAIL fault_clear: got %b want %b", obs, V_Z);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_muladd();
        test_jump();
        test_illegal();
        test_halt();
        test_mid_reset();
        test_bad_rori();
        test_timeout_edge();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
